lcd_char_bus_ctrl: RTL and testbench

Avalon-MM slave that receives command and character writes from user_interface_fsm and turns each one into one HD44780-style LCD bus cycle. It drives LCD_RS, LCD_RW, LCD_EN and LCD_DATA with the setup, enable-width, hold and execution timing the panel requires. Waitrequest stalls the master until the panel can take the next byte. It sits directly downstream of the UI FSM and directly drives the board's character LCD pins.

---
 rtl/lcd_char_bus_ctrl_if.sv | 39 +++
 rtl/lcd_char_bus_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_lcd_char_bus_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_char_bus_ctrl_if.sv
// lcd_char_bus_ctrl_if
//
// Avalon-MM slave port bundle for lcd_char_bus_ctrl.
// It carries the single-byte command and character writes coming from
// user_interface_fsm, together with the slave's handshake and response.
//
// Signals:
//   address     master->slave  0 = command byte (RS=0), 1 = data byte (RS=1)
//   chipselect  master->slave  slave select
//   byteenable  master->slave  0 makes a write a no-op
//   read        master->slave  read strobe
//   write       master->slave  write strobe
//   writedata   master->slave  command or character byte
//   waitrequest slave->master  high = transfer not accepted this cycle
//   readdata    slave->master  read data (always 0x00)
//   response    slave->master  00 OKAY, 10 SLVERR
//
// Modports: master (UI FSM / testbench side), slave (controller side).
interface lcd_char_bus_ctrl_if;
  logic       address;
  logic       chipselect;
  logic       byteenable;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic       waitrequest;
  logic [7:0] readdata;
  logic [1:0] response;

  modport master (
    output address, chipselect, byteenable, read, write, writedata,
    input  waitrequest, readdata, response
  );

  modport slave (
    input  address, chipselect, byteenable, read, write, writedata,
    output waitrequest, readdata, response
  );
endinterface

// File: rtl/lcd_char_bus_ctrl.sv
// lcd_char_bus_ctrl
//
// Avalon-MM slave that turns each command/character write into one
// HD44780-style LCD bus cycle: RS/DATA setup, an LCD_EN pulse, RS/DATA
// hold, then the panel's execution wait (longer for clear and home).
// waitrequest holds the master off until the panel can take another byte.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high; restarts the power-up wait and
//             drops LCD_EN immediately
//   bus       lcd_char_bus_ctrl_if.slave Avalon-MM port
//   LCD_DATA  panel data bus
//   LCD_RS    register select (0 = command, 1 = data)
//   LCD_RW    read/write select, tied to 0 (write-only)
//   LCD_EN    enable strobe
//   LCD_ON    panel power, constant 1
//   LCD_BLON  backlight, constant 1
//
// Build option:
//   LCD_WRITE_FIFO_EN  when defined, a 4-entry {RS, DATA} FIFO decouples the
//                      Avalon port from the LCD sequencer so the master can
//                      queue bytes, even during power-up. When undefined the
//                      controller accepts one byte at a time from IDLE only.
module lcd_char_bus_ctrl #(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_HIGH_CYC    = 12,
  parameter int HOLD_CYC       = 2,
  parameter int EXEC_CYC       = 2500,
  parameter int CLEAR_EXEC_CYC = 82000
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_char_bus_ctrl_if.slave   bus,
  output logic [7:0]           LCD_DATA,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  output logic                 LCD_EN,
  output logic                 LCD_ON,
  output logic                 LCD_BLON
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC),
                                     max2(EN_HIGH_CYC, HOLD_CYC)),
                                max2(EXEC_CYC, CLEAR_EXEC_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    POWERUP,
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    EXEC
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [CNT_W-1:0]   exec_last;

  logic               lcd_rs_q;
  logic [7:0]         lcd_data_q;
  logic               clear_q;
  logic               en_q;
  logic [1:0]         resp_q;
  logic [7:0]         rdata_q;

  logic               req;
  logic               accept;
  logic               start;
  logic               start_rs;
  logic [7:0]         start_data;

  assign req = bus.chipselect && (bus.write || bus.read);

`ifdef LCD_WRITE_FIFO_EN
  // Queue of {RS, DATA}. The port accepts whenever there is room, so the
  // master is only stalled by a full queue; the sequencer drains it one
  // entry per LCD cycle once it reaches IDLE after power-up.
  logic [8:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_full, fifo_empty;
  logic       push, pop;

  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign accept     = req && !fifo_full;
  assign push       = accept && bus.write && bus.byteenable;
  assign start      = (state == IDLE) && !fifo_empty;
  assign pop        = start;
  assign start_rs   = fifo_mem[rd_ptr][8];
  assign start_data = fifo_mem[rd_ptr][7:0];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.address, bus.writedata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  // Single-byte mode: a request is only taken in IDLE, and only a real
  // write (byteenable set) starts an LCD cycle. No-op writes and reads are
  // answered without leaving IDLE, so they can be issued back to back.
  assign accept     = (state == IDLE) && req;
  assign start      = accept && bus.write && bus.byteenable;
  assign start_rs   = bus.address;
  assign start_data = bus.writedata;
`endif

  assign bus.waitrequest = !accept;
  assign bus.readdata    = rdata_q;
  assign bus.response    = resp_q;

  // Clear (0x01) and home (0x02) commands need the long execution wait.
  assign exec_last = clear_q ? CNT_W'(CLEAR_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);

  // State and phase counter register. The counter is shared by all phases
  // and restarts from zero at every phase entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= POWERUP;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: each timed phase lasts until the counter reaches its
  // length minus one, then moves on with the counter cleared.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    case (state)
      POWERUP: begin
        if (cnt == CNT_W'(POWERUP_CYC - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          state_next = EN_HI;
          cnt_next   = '0;
        end
      end
      EN_HI: begin
        if (cnt == CNT_W'(EN_HIGH_CYC - 1)) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          state_next = EXEC;
          cnt_next   = '0;
        end
      end
      EXEC: begin
        if (cnt == exec_last) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = POWERUP;
        cnt_next   = '0;
      end
    endcase
  end

  // Pin and response registers. LCD_EN is registered from the next state so
  // the strobe is glitch-free yet still high exactly while in EN_HI; RS/DATA
  // only load when a new LCD cycle starts, so they never move under EN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
      clear_q    <= 1'b0;
      en_q       <= 1'b0;
      resp_q     <= 2'b00;
      rdata_q    <= 8'h00;
    end else begin
      en_q <= (state_next == EN_HI);
      if (start) begin
        lcd_rs_q   <= start_rs;
        lcd_data_q <= start_data;
        clear_q    <= !start_rs && ((start_data == 8'h01) || (start_data == 8'h02));
      end
      if (accept) begin
        rdata_q <= 8'h00;
        resp_q  <= (bus.read && !bus.write) ? 2'b10 : 2'b00;
      end
    end
  end

  assign LCD_DATA = lcd_data_q;
  assign LCD_RS   = lcd_rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = en_q;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_char_bus_ctrl.sv
// tb_lcd_char_bus_ctrl
//
// Self-checking bench for lcd_char_bus_ctrl (single-byte build). A timeline
// model tracks, in absolute cycle numbers since reset release, when the
// slave is next free, which cycles LCD_EN must be high, and what RS/DATA and
// the response must show. Directed scenarios come first, then random traffic.
module tb_lcd_char_bus_ctrl;

  localparam int P_PWR   = 20;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 4;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 10;
  localparam int P_CLEAR = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

  lcd_char_bus_ctrl_if bus_if ();

  lcd_char_bus_ctrl #(
    .POWERUP_CYC   (P_PWR),
    .SETUP_CYC     (P_SETUP),
    .EN_HIGH_CYC   (P_EN),
    .HOLD_CYC      (P_HOLD),
    .EXEC_CYC      (P_EXEC),
    .CLEAR_EXEC_CYC(P_CLEAR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .LCD_DATA(lcd_data),
    .LCD_RS  (lcd_rs),
    .LCD_RW  (lcd_rw),
    .LCD_EN  (lcd_en),
    .LCD_ON  (lcd_on),
    .LCD_BLON(lcd_blon)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;

  // Timeline model state
  int         cyc;
  int         next_free;
  int         en_first;
  int         en_last;
  logic       exp_rs;
  logic [7:0] exp_data;
  logic [1:0] exp_resp;
  logic       dut_acc;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               tag, cyc, actual, expected);
    end
  endtask

  task automatic resetModel();
    cyc       = 0;
    next_free = P_PWR;
    en_first  = -1;
    en_last   = -2;
    exp_rs    = 1'b0;
    exp_data  = 8'h00;
    exp_resp  = 2'b00;
  endtask

  // Drive one cycle of master signals, check every output against the
  // timeline, then advance the timeline with the model's accept decision.
  task automatic applyStimulus(input logic cs, input logic addr, input logic be,
                               input logic rd, input logic wr, input logic [7:0] data);
    logic req;
    logic model_acc;
    int   exec;
    @(negedge clk);
    bus_if.chipselect = cs;
    bus_if.address    = addr;
    bus_if.byteenable = be;
    bus_if.read       = rd;
    bus_if.write      = wr;
    bus_if.writedata  = data;
    #1;
    req       = cs && (rd || wr);
    model_acc = req && (cyc >= next_free);
    checkOutput("waitrequest", bus_if.waitrequest, !model_acc);
    checkOutput("lcd_en", lcd_en, (cyc >= en_first) && (cyc <= en_last));
    checkOutput("lcd_rs", lcd_rs, exp_rs);
    checkOutput("lcd_data", lcd_data, exp_data);
    checkOutput("response", bus_if.response, exp_resp);
    checkOutput("readdata", bus_if.readdata, 8'h00);
    checkOutput("rw_on_blon", {lcd_rw, lcd_on, lcd_blon}, 3'b011);
    dut_acc = req && !bus_if.waitrequest;
    if (model_acc) begin
      exp_resp = (rd && !wr) ? 2'b10 : 2'b00;
      if (wr && be) begin
        exec      = (!addr && (data == 8'h01 || data == 8'h02)) ? P_CLEAR : P_EXEC;
        exp_rs    = addr;
        exp_data  = data;
        en_first  = cyc + 1 + P_SETUP;
        en_last   = cyc + P_SETUP + P_EN;
        next_free = cyc + 1 + P_SETUP + P_EN + P_HOLD + exec;
      end else begin
        next_free = cyc + 1;
      end
    end
    cyc++;
  endtask

  // Hold a request until the DUT takes it; report the acceptance cycle.
  task automatic doRequest(input logic addr, input logic be, input logic rd,
                           input logic wr, input logic [7:0] data, output int acc_cyc);
    acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, addr, be, rd, wr, data);
      if (dut_acc) begin
        acc_cyc = cyc - 1;
        break;
      end
    end
    if (acc_cyc < 0) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  // Cycles with no valid request: either deselected with random strobes, or
  // selected with both strobes low.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 8'($urandom));
      end else begin
        applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 8'($urandom));
      end
    end
  endtask

  // Assert reset asynchronously, verify the pins fall at once, then release
  // just after a rising edge so the next negedge starts cycle 0.
  task automatic doReset();
    reset = 1'b1;
    #1;
    checkOutput("rst_lcd_en", lcd_en, 1'b0);
    checkOutput("rst_lcd_rs", lcd_rs, 1'b0);
    checkOutput("rst_lcd_data", lcd_data, 8'h00);
    checkOutput("rst_response", bus_if.response, 2'b00);
    checkOutput("rst_readdata", bus_if.readdata, 8'h00);
    checkOutput("rst_rw_on_blon", {lcd_rw, lcd_on, lcd_blon}, 3'b011);
    @(posedge clk);
    #2;
    reset = 1'b0;
    resetModel();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   t0, t1;
    int   kind;
    logic addr, be, rd, wr;
    logic [7:0] data;

    reset             = 1'b0;
    bus_if.chipselect = 1'b0;
    bus_if.address    = 1'b0;
    bus_if.byteenable = 1'b0;
    bus_if.read       = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.writedata  = 8'h00;
    resetModel();
    #1;
    doReset();

    $display("[TB] power-up stall and first data write");
    doRequest(1'b1, 1'b1, 1'b0, 1'b1, 8'h4B, t0);
    checkOutput("powerup_accept_cycle", t0, P_PWR);
    doRequest(1'b1, 1'b1, 1'b0, 1'b1, 8'h4C, t1);
    checkOutput("data_write_spacing", t1 - t0, 1 + P_SETUP + P_EN + P_HOLD + P_EXEC);

    $display("[TB] clear command then display-on command");
    doRequest(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, t0);
    doRequest(1'b0, 1'b1, 1'b0, 1'b1, 8'h0C, t1);
    checkOutput("clear_spacing", t1 - t0, 1 + P_SETUP + P_EN + P_HOLD + P_CLEAR);

    $display("[TB] byteenable=0 write then real write");
    doRequest(1'b0, 1'b0, 1'b0, 1'b1, 8'h55, t0);
    doRequest(1'b1, 1'b1, 1'b0, 1'b1, 8'h41, t1);
    checkOutput("noop_back_to_back", t1 - t0, 1);

    $display("[TB] read in IDLE");
    doRequest(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, t0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("read_response", bus_if.response, 2'b10);
    checkOutput("read_readdata", bus_if.readdata, 8'h00);

    $display("[TB] reset during enable pulse");
    doRequest(1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, t0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    checkOutput("en_high_before_reset", lcd_en, 1'b1);
    doReset();
    doRequest(1'b1, 1'b1, 1'b0, 1'b1, 8'h33, t1);
    checkOutput("accept_after_reset", t1, P_PWR);

    $display("[TB] random traffic");
    for (int n = 0; n < 150; n++) begin
      idleCycles($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      addr = 1'($urandom);
      be   = ($urandom_range(0, 4) != 0);
      data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        data = 8'($urandom_range(1, 2));
      end
      rd = (kind >= 7);
      wr = (kind != 7);
      doRequest(addr, be, rd, wr, data, t0);
    end
    idleCycles(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
